// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered-latency ALU between two valid/ready requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arbiter #(
   parameter int WIDTH   = 16,
   parameter int ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [1:0]       req0_op,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic [WIDTH-1:0] resp0_result,
   output logic             resp0_z,
   output logic             resp0_n,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req1_op,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [WIDTH-1:0] resp1_result,
   output logic             resp1_z,
   output logic             resp1_n,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_z,
   input  logic             alu_n,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             gnt_q, gnt_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [1:0]       alu_op_q, alu_op_d;
   logic             resp0_valid_q, resp0_valid_d, resp1_valid_q, resp1_valid_d;
   logic [WIDTH-1:0] resp0_result_q, resp0_result_d, resp1_result_q, resp1_result_d;
   logic             resp0_z_q, resp0_z_d, resp0_n_q, resp0_n_d;
   logic             resp1_z_q, resp1_z_d, resp1_n_q, resp1_n_d;
   logic             win0, win1, accept, capture, done;
`ifdef ALU_ARB_FIXED_PRIO_EN
   assign win0 = req0_valid;
   assign win1 = req1_valid & ~req0_valid;
`else
   logic last_q, last_d;
   // on a tie the requester that was not granted last time wins
   assign win0 = req0_valid & (~req1_valid | last_q);
   assign win1 = req1_valid & (~req0_valid | ~last_q);
   always_comb last_d = accept ? req1_ready : last_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) last_q <= 1'b1;
      else last_q <= last_d;
`endif
   assign req0_ready = ~rst & (state_q == IDLE) & win0;
   assign req1_ready = ~rst & (state_q == IDLE) & win1;
   assign accept  = req0_ready | req1_ready;
   assign capture = (state_q == EXEC) & (cnt_q == 4'(ALU_LAT));
   assign done    = (state_q == RESP) & (gnt_q ? resp1_ready : resp0_ready);
   always_comb begin
      state_d        = accept ? EXEC : capture ? RESP : done ? IDLE : state_q;
      cnt_d          = accept ? 4'd0 : (state_q == EXEC) ? cnt_q + 4'd1 : cnt_q;
      gnt_d          = accept ? req1_ready : gnt_q;
      alu_a_d        = req1_ready ? req1_a : req0_ready ? req0_a : alu_a_q;
      alu_b_d        = req1_ready ? req1_b : req0_ready ? req0_b : alu_b_q;
      alu_op_d       = req1_ready ? req1_op : req0_ready ? req0_op : alu_op_q;
      resp0_valid_d  = (capture & ~gnt_q) ? 1'b1 : (done & ~gnt_q) ? 1'b0 : resp0_valid_q;
      resp1_valid_d  = (capture & gnt_q) ? 1'b1 : (done & gnt_q) ? 1'b0 : resp1_valid_q;
      resp0_result_d = (capture & ~gnt_q) ? alu_result : resp0_result_q;
      resp0_z_d      = (capture & ~gnt_q) ? alu_z : resp0_z_q;
      resp0_n_d      = (capture & ~gnt_q) ? alu_n : resp0_n_q;
      resp1_result_d = (capture & gnt_q) ? alu_result : resp1_result_q;
      resp1_z_d      = (capture & gnt_q) ? alu_z : resp1_z_q;
      resp1_n_d      = (capture & gnt_q) ? alu_n : resp1_n_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= 4'd0;
         gnt_q          <= 1'b0;
         alu_a_q        <= '0;
         alu_b_q        <= '0;
         alu_op_q       <= 2'b00;
         resp0_valid_q  <= 1'b0;
         resp1_valid_q  <= 1'b0;
         resp0_result_q <= '0;
         resp1_result_q <= '0;
         resp0_z_q      <= 1'b0;
         resp0_n_q      <= 1'b0;
         resp1_z_q      <= 1'b0;
         resp1_n_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         gnt_q          <= gnt_d;
         alu_a_q        <= alu_a_d;
         alu_b_q        <= alu_b_d;
         alu_op_q       <= alu_op_d;
         resp0_valid_q  <= resp0_valid_d;
         resp1_valid_q  <= resp1_valid_d;
         resp0_result_q <= resp0_result_d;
         resp1_result_q <= resp1_result_d;
         resp0_z_q      <= resp0_z_d;
         resp0_n_q      <= resp0_n_d;
         resp1_z_q      <= resp1_z_d;
         resp1_n_q      <= resp1_n_d;
      end
   end
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_op       = alu_op_q;
   assign resp0_valid  = resp0_valid_q;
   assign resp1_valid  = resp1_valid_q;
   assign resp0_result = resp0_result_q;
   assign resp1_result = resp1_result_q;
   assign resp0_z      = resp0_z_q;
   assign resp0_n      = resp0_n_q;
   assign resp1_z      = resp1_z_q;
   assign resp1_n      = resp1_n_q;
   assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with ALU models of latency 1 and 3.
module tb_alu_arbiter;
   localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND_ = 2'b10, OR_ = 2'b11;
   typedef struct packed {logic idx; logic [15:0] r; logic z; logic n;} exp_t;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic req0_valid = 0, req1_valid = 0, resp0_ready = 1, resp1_ready = 1;
   logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic [1:0] req0_op = 0, req1_op = 0;
   logic req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_z, resp0_n, resp1_z, resp1_n, busy;
   logic [15:0] resp0_result, resp1_result, alu_a, alu_b, alu_result;
   logic [1:0] alu_op;
   logic alu_z, alu_n;
   logic l3_req0_valid = 0, l3_req1_valid = 0, l3_resp0_ready = 1, l3_resp1_ready = 1;
   logic [15:0] l3_req0_a = 0, l3_req0_b = 0, l3_req1_a = 0, l3_req1_b = 0;
   logic [1:0] l3_req0_op = 0, l3_req1_op = 0;
   logic l3_req0_ready, l3_req1_ready, l3_resp0_valid, l3_resp1_valid, l3_resp0_z, l3_resp0_n, l3_resp1_z, l3_resp1_n, l3_busy;
   logic [15:0] l3_resp0_result, l3_resp1_result, l3_alu_a, l3_alu_b, l3_alu_result;
   logic [1:0] l3_alu_op;
   logic l3_alu_z, l3_alu_n;
   logic [17:0] l3_pipe [3];
   exp_t sb[$];
   int n_cmp = 0, n_bad = 0;

   function automatic logic [17:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
      logic [15:0] r;
      r = (op == ADD) ? a + b : (op == SUB) ? a - b : (op == AND_) ? (a & b) : (a | b);
      return {r == 16'd0, r[15], r};
   endfunction

   always @(posedge clk) {alu_z, alu_n, alu_result} <= alu_f(alu_a, alu_b, alu_op);
   always @(posedge clk) begin
      l3_pipe[0] <= alu_f(l3_alu_a, l3_alu_b, l3_alu_op);
      l3_pipe[1] <= l3_pipe[0];
      l3_pipe[2] <= l3_pipe[1];
   end
   assign {l3_alu_z, l3_alu_n, l3_alu_result} = l3_pipe[2];

   alu_arbiter #(.WIDTH(16), .ALU_LAT(1)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result), .resp0_z(resp0_z), .resp0_n(resp0_n),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result), .resp1_z(resp1_z), .resp1_n(resp1_n),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_z(alu_z), .alu_n(alu_n), .busy(busy));

   alu_arbiter #(.WIDTH(16), .ALU_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .req0_valid(l3_req0_valid), .req0_ready(l3_req0_ready), .req0_a(l3_req0_a), .req0_b(l3_req0_b), .req0_op(l3_req0_op),
      .resp0_valid(l3_resp0_valid), .resp0_ready(l3_resp0_ready), .resp0_result(l3_resp0_result), .resp0_z(l3_resp0_z), .resp0_n(l3_resp0_n),
      .req1_valid(l3_req1_valid), .req1_ready(l3_req1_ready), .req1_a(l3_req1_a), .req1_b(l3_req1_b), .req1_op(l3_req1_op),
      .resp1_valid(l3_resp1_valid), .resp1_ready(l3_resp1_ready), .resp1_result(l3_resp1_result), .resp1_z(l3_resp1_z), .resp1_n(l3_resp1_n),
      .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_op(l3_alu_op), .alu_result(l3_alu_result), .alu_z(l3_alu_z), .alu_n(l3_alu_n), .busy(l3_busy));

   // drive one request, wait for its accept edge, push the expected response
   task automatic issue(input logic idx, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op, output logic ok);
      logic [17:0] f;
      int n;
      if (idx) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
      else begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
      #1;
      n = 0;
      while (!(idx ? req1_ready : req0_ready) && n < 20) begin @(negedge clk); n++; end
      ok = idx ? req1_ready : req0_ready;
      if (ok) begin
         @(posedge clk);
         f = alu_f(a, b, op);
         sb.push_back({idx, f[15:0], f[17], f[16]});
      end
      @(negedge clk);
      if (idx) req1_valid = 0; else req0_valid = 0;
   endtask

   task automatic wait_resp(input int lim, output exp_t got, output int waited, output logic ok);
      waited = 0; ok = 0; got = '0;
      while (!ok && waited < lim) begin
         @(negedge clk); waited++;
         if (resp1_valid) begin ok = 1; got = {1'b1, resp1_result, resp1_z, resp1_n}; end
         else if (resp0_valid) begin ok = 1; got = {1'b0, resp0_result, resp0_z, resp0_n}; end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      req0_valid = 1; #1;
      n_cmp++; if ({req0_ready, req1_ready, busy} !== 3'b000) begin n_bad++; $display("FAIL reset_ctrl: got %b want 000", {req0_ready, req1_ready, busy}); end
      n_cmp++; if ({resp0_valid, resp1_valid, resp0_result, resp1_result, resp0_z, resp0_n, resp1_z, resp1_n} !== '0) begin n_bad++; $display("FAIL reset_resp: got %h want 0", {resp0_valid, resp1_valid, resp0_result, resp1_result, resp0_z, resp0_n, resp1_z, resp1_n}); end
      n_cmp++; if ({alu_a, alu_b, alu_op, l3_busy} !== '0) begin n_bad++; $display("FAIL reset_alu: got %h want 0", {alu_a, alu_b, alu_op, l3_busy}); end
      req0_valid = 0;
      @(negedge clk); rst = 0;
   endtask

   task automatic test_single();
      logic ok; exp_t got, e; int w;
      issue(0, 16'h0003, 16'h0004, ADD, ok);
      n_cmp++; if ({alu_op, alu_a, alu_b, busy} !== {ADD, 16'h0003, 16'h0004, 1'b1}) begin n_bad++; $display("FAIL single_alu: got %h want %h", {alu_op, alu_a, alu_b, busy}, {ADD, 16'h0003, 16'h0004, 1'b1}); end
      wait_resp(10, got, w, ok);
      n_cmp++; if (!ok || w != 2) begin n_bad++; $display("FAIL single_latency: got valid=%b after %0d edges want 2", ok, w); end
      e = sb.size() ? sb.pop_front() : '0;
      n_cmp++; if (got !== e) begin n_bad++; $display("FAIL single_sb: got %h want %h", got, e); end
      n_cmp++; if (got !== {1'b0, 16'h0007, 2'b00}) begin n_bad++; $display("FAIL single_const: got %h want %h", got, {1'b0, 16'h0007, 2'b00}); end
      @(negedge clk);
      n_cmp++; if ({resp0_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL single_done: got %b want 00", {resp0_valid, busy}); end
   endtask

   task automatic test_sub();
      logic ok, ok2; exp_t got, e, want; int w;
      for (int k = 0; k < 2; k++) begin
         want = k ? {1'b1, 16'hFFFF, 1'b0, 1'b1} : {1'b1, 16'h0000, 1'b1, 1'b0};
         issue(1, k ? 16'h0001 : 16'h1234, k ? 16'h0002 : 16'h1234, SUB, ok);
         wait_resp(10, got, w, ok2);
         e = sb.size() ? sb.pop_front() : '0;
         n_cmp++; if (!ok2 || got !== e) begin n_bad++; $display("FAIL sub_sb%0d: got %h want %h", k, got, e); end
         n_cmp++; if (got !== want) begin n_bad++; $display("FAIL sub_const%0d: got %h want %h", k, got, want); end
         @(negedge clk);
      end
   endtask

   task automatic test_contention();
      logic ok, g; exp_t got, e; int w, n, exp_g; logic [17:0] f;
      req0_valid = 1; req0_a = 16'h0101; req0_b = 16'h0010; req0_op = ADD;
      req1_valid = 1; req1_a = 16'hF0F0; req1_b = 16'h0FF0; req1_op = AND_;
      for (int k = 0; k < 4; k++) begin
         #1; n = 0;
         while (!(req0_ready || req1_ready) && n < 20) begin @(negedge clk); n++; end
         g = req1_ready;
`ifdef ALU_ARB_FIXED_PRIO_EN
         exp_g = 0;
`else
         exp_g = k % 2;
`endif
         n_cmp++; if (!(req0_ready || req1_ready) || g !== exp_g[0]) begin n_bad++; $display("FAIL contention_grant%0d: got %b want %0d", k, g, exp_g); end
         @(posedge clk);
         f = g ? alu_f(req1_a, req1_b, req1_op) : alu_f(req0_a, req0_b, req0_op);
         sb.push_back({g, f[15:0], f[17], f[16]});
         @(negedge clk);
         if (g) req1_a = req1_a + 16'h0111; else req0_a = req0_a + 16'h0222;
         wait_resp(10, got, w, ok);
         e = sb.size() ? sb.pop_front() : '0;
         n_cmp++; if (!ok || got !== e) begin n_bad++; $display("FAIL contention_resp%0d: got %h want %h", k, got, e); end
      end
      req0_valid = 0; req1_valid = 0;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic ok; exp_t got, e; int w; logic [17:0] f;
      resp0_ready = 0;
      issue(0, 16'h8000, 16'h0001, OR_, ok);
      req1_valid = 1; req1_a = 16'h0F00; req1_b = 16'h00F0; req1_op = OR_;
      wait_resp(10, got, w, ok);
      e = sb.size() ? sb.pop_front() : '0;
      n_cmp++; if (!ok || got !== e || got !== {1'b0, 16'h8001, 1'b0, 1'b1}) begin n_bad++; $display("FAIL bp_resp: got %h want %h", got, e); end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_cmp++; if ({resp0_valid, busy, req1_ready, resp0_result} !== {1'b1, 1'b1, 1'b0, e.r}) begin n_bad++; $display("FAIL bp_hold%0d: got %h want %h", k, {resp0_valid, busy, req1_ready, resp0_result}, {1'b1, 1'b1, 1'b0, e.r}); end
      end
      resp0_ready = 1;
      @(negedge clk);
      n_cmp++; if ({busy, resp0_valid, req1_ready} !== 3'b001) begin n_bad++; $display("FAIL bp_release: got %b want 001", {busy, resp0_valid, req1_ready}); end
      @(posedge clk);
      f = alu_f(req1_a, req1_b, req1_op);
      sb.push_back({1'b1, f[15:0], f[17], f[16]});
      @(negedge clk);
      n_cmp++; if ({busy, alu_a} !== {1'b1, 16'h0F00}) begin n_bad++; $display("FAIL bp_accept1: got %h want %h", {busy, alu_a}, {1'b1, 16'h0F00}); end
      req1_valid = 0;
      wait_resp(10, got, w, ok);
      e = sb.size() ? sb.pop_front() : '0;
      n_cmp++; if (!ok || got !== e) begin n_bad++; $display("FAIL bp_resp1: got %h want %h", got, e); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic ok; exp_t got, e; int w, seen; logic [17:0] f;
      issue(0, 16'h0005, 16'h0006, ADD, ok);
      @(posedge clk); #1 rst = 1; #1;
      n_cmp++; if ({busy, resp0_valid, resp1_valid, req0_ready, req1_ready, alu_a, alu_b, alu_op, resp0_result, resp1_result, resp0_n} !== '0) begin n_bad++; $display("FAIL rstmid_outputs: got %h want 0", {busy, resp0_valid, resp1_valid, req0_ready, req1_ready, alu_a, alu_b, alu_op, resp0_result, resp1_result, resp0_n}); end
      sb.delete();
      @(negedge clk); @(negedge clk); rst = 0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin @(negedge clk); if (resp0_valid || resp1_valid || busy) seen++; end
      n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rstmid_no_resp: got %0d active cycles want 0", seen); end
      req0_valid = 1; req0_a = 16'h0009; req0_b = 16'h0009; req0_op = SUB;
      req1_valid = 1; req1_a = 16'h0001; req1_b = 16'h0001; req1_op = ADD;
      #1;
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL rstmid_tie: got %b want 10", {req0_ready, req1_ready}); end
      @(posedge clk);
      f = alu_f(16'h0009, 16'h0009, SUB);
      sb.push_back({1'b0, f[15:0], f[17], f[16]});
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      wait_resp(10, got, w, ok);
      e = sb.size() ? sb.pop_front() : '0;
      n_cmp++; if (!ok || got !== e || got !== {1'b0, 16'h0000, 1'b1, 1'b0}) begin n_bad++; $display("FAIL rstmid_after: got %h want %h", got, e); end
      @(negedge clk);
   endtask

   task automatic test_lat3();
      exp_t e; int w, drift; logic [17:0] f; logic [33:0] snap;
      l3_req0_valid = 1; l3_req0_a = 16'h7FFF; l3_req0_b = 16'h0001; l3_req0_op = ADD;
      #1;
      n_cmp++; if (l3_req0_ready !== 1'b1) begin n_bad++; $display("FAIL lat3_ready: got %b want 1", l3_req0_ready); end
      @(posedge clk);
      f = alu_f(16'h7FFF, 16'h0001, ADD);
      sb.push_back({1'b0, f[15:0], f[17], f[16]});
      @(negedge clk);
      l3_req0_valid = 0;
      snap = {l3_alu_a, l3_alu_b, l3_alu_op};
      n_cmp++; if (snap !== {16'h7FFF, 16'h0001, ADD}) begin n_bad++; $display("FAIL lat3_alu: got %h want %h", snap, {16'h7FFF, 16'h0001, ADD}); end
      w = 0; drift = 0;
      while (!l3_resp0_valid && w < 12) begin
         @(negedge clk); w++;
         if ({l3_alu_a, l3_alu_b, l3_alu_op} !== snap) drift++;
      end
      n_cmp++; if (w != 4 || drift != 0) begin n_bad++; $display("FAIL lat3_timing: got %0d edges drift %0d want 4 edges drift 0", w, drift); end
      e = sb.size() ? sb.pop_front() : '0;
      n_cmp++; if ({l3_resp0_valid, l3_resp0_result, l3_resp0_z, l3_resp0_n} !== {1'b1, e.r, e.z, e.n} || e.r !== 16'h8000) begin n_bad++; $display("FAIL lat3_resp: got %h want %h", {l3_resp0_valid, l3_resp0_result, l3_resp0_z, l3_resp0_n}, {1'b1, e.r, e.z, e.n}); end
      @(negedge clk);
      n_cmp++; if ({l3_busy, l3_resp0_valid} !== 2'b00) begin n_bad++; $display("FAIL lat3_done: got %b want 00", {l3_busy, l3_resp0_valid}); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_sub();
      test_contention();
      test_backpressure();
      test_reset_mid();
      test_lat3();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
